// File: rtl/key_event_scanner.sv
// Debounces 13 push-buttons on a shared sample tick and queues press/release
// events, lowest key first, into a small registered FIFO with sticky overflow.
module key_event_scanner #(
  parameter int TICK_CYCLES = 50000,
  parameter int DEB_TICKS   = 8,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] keys_raw,
  output logic [12:0] keys_stable,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [4:0]  ev_data,
  output logic        overflow,
  input  logic        clr_ovf
);

  localparam int NK = 13;
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [NK-1:0] sync1_q, sync2_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]    mis_q [NK];
  logic [3:0]    mis_d [NK];
  logic [NK-1:0] stable_q, stable_d;
  logic [NK-1:0] pend_q, pend_d;
  logic          ovf_q, ovf_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [4:0]    mem [FIFO_DEPTH];

  logic          tick;
  logic          empty, full, pop, push, found;
  logic [NK-1:0] push_sel;
  logic [3:0]    push_idx;
  logic          push_bit;
  logic [4:0]    push_data;
  logic          ovf_set;

  assign tick       = (tick_cnt_q == TW'(TICK_CYCLES - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

  // Extra pointer bit separates full from empty when the indices coincide.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && ev_ready;

  always_comb begin
    push_sel = '0;
    push_idx = '0;
    push_bit = 1'b0;
    found    = 1'b0;
    for (int i = NK - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        push_sel    = '0;
        push_sel[i] = 1'b1;
        push_idx    = 4'(i);
        push_bit    = stable_q[i];
        found       = 1'b1;
      end
    end
  end

  assign push      = found && (!full || pop);
  assign push_data = {push_bit, push_idx};
  assign wr_ptr_d  = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
  assign rd_ptr_d  = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

  // A flip whose previous event is still pending (and not leaving this cycle)
  // overwrites that event: the newer level is what gets reported.
  always_comb begin
    stable_d = stable_q;
    pend_d   = pend_q & ~(push ? push_sel : '0);
    ovf_set  = 1'b0;
    for (int i = 0; i < NK; i++) begin
      mis_d[i] = mis_q[i];
      if (tick) begin
        if (sync2_q[i] != stable_q[i]) begin
          if (mis_q[i] == 4'(DEB_TICKS - 1)) begin
            stable_d[i] = ~stable_q[i];
            mis_d[i]    = '0;
            if (pend_d[i]) ovf_set = 1'b1;
            pend_d[i]   = 1'b1;
          end else begin
            mis_d[i] = mis_q[i] + 4'd1;
          end
        end else begin
          mis_d[i] = '0;
        end
      end
    end
  end

  assign ovf_d = ovf_set ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      tick_cnt_q <= '0;
      stable_q   <= '0;
      pend_q     <= '0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < NK; i++) mis_q[i] <= '0;
    end else begin
      sync1_q    <= keys_raw;
      sync2_q    <= sync1_q;
      tick_cnt_q <= tick_cnt_d;
      stable_q   <= stable_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      for (int i = 0; i < NK; i++) mis_q[i] <= mis_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

  // Head is masked while empty so ev_data reads zero out of reset.
  assign keys_stable = stable_q;
  assign ev_valid    = !empty;
  assign ev_data     = empty ? 5'd0 : mem[rd_ptr_q[AW-1:0]];
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_key_event_scanner.sv
// Bench for key_event_scanner: directed scenarios plus random key activity,
// checked every cycle against a queue-based reference model.
module tb_key_event_scanner;
  localparam int TC = 4;
  localparam int DT = 3;
  localparam int FD = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] keys_raw = '0;
  logic [12:0] keys_stable;
  logic        ev_valid;
  logic        ev_ready = 1'b0;
  logic [4:0]  ev_data;
  logic        overflow;
  logic        clr_ovf = 1'b0;

  always #5 clk = ~clk;

  key_event_scanner #(.TICK_CYCLES(TC), .DEB_TICKS(DT), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .keys_raw(keys_raw), .keys_stable(keys_stable),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );

  // Reference model state
  bit [12:0]  m_s1, m_s2, m_stable, m_pend;
  int         m_cnt [13];
  int         m_tc;
  bit         m_ovf;
  logic [4:0] m_q [$];

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_pend = '0;
    m_tc = 0; m_ovf = 1'b0;
    for (int i = 0; i < 13; i++) m_cnt[i] = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit         tick, pop, do_push, set;
    int         pi;
    logic [4:0] pd;
    tick = (m_tc == TC - 1);
    m_tc = (m_tc + 1) % TC;
    pop  = (m_q.size() > 0) && ev_ready;
    pi   = -1;
    for (int i = 0; i < 13; i++) if (m_pend[i] && pi < 0) pi = i;
    do_push = (pi >= 0) && ((m_q.size() < FD) || pop);
    pd = '0;
    if (do_push) pd = {m_stable[pi], 4'(pi)};
    if (pop) void'(m_q.pop_front());
    if (do_push) begin
      m_q.push_back(pd);
      m_pend[pi] = 1'b0;
    end
    set = 1'b0;
    if (tick) begin
      for (int i = 0; i < 13; i++) begin
        if (m_s2[i] != m_stable[i]) begin
          m_cnt[i]++;
          if (m_cnt[i] == DT) begin
            m_stable[i] = ~m_stable[i];
            m_cnt[i] = 0;
            if (m_pend[i]) set = 1'b1;
            m_pend[i] = 1'b1;
          end
        end else begin
          m_cnt[i] = 0;
        end
      end
    end
    m_ovf = set ? 1'b1 : (clr_ovf ? 1'b0 : m_ovf);
    m_s2 = m_s1;
    m_s1 = keys_raw;
  endtask

  task automatic check_all();
    chk("keys_stable", 32'(keys_stable), 32'(m_stable));
    chk("ev_valid", 32'(ev_valid), 32'(m_q.size() > 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (m_q.size() > 0) chk("ev_data", 32'(ev_data), 32'(m_q[0]));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_stable", 32'(keys_stable), 32'd0);
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_data", 32'(ev_data), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;

    // Single key press and release
    ev_ready = 1'b1;
    keys_raw[0] = 1'b1;
    run(30);
    chk("s1_press", 32'(keys_stable[0]), 32'd1);
    keys_raw[0] = 1'b0;
    run(30);

    // Bouncing key never settles long enough
    for (int k = 0; k < 12; k++) begin
      keys_raw[2] = ~keys_raw[2];
      run(5);
    end
    keys_raw[2] = 1'b0;
    run(20);
    chk("s2_bounce", 32'(keys_stable[2]), 32'd0);

    // Two keys on the same tick
    keys_raw[0] = 1'b1;
    keys_raw[12] = 1'b1;
    run(25);
    keys_raw = '0;
    run(25);

    // Fill the FIFO, hold a pending event, then overflow on key 8
    ev_ready = 1'b0;
    keys_raw[8:0] = 9'h1ff;
    run(25);
    chk("s4_full_valid", 32'(ev_valid), 32'd1);
    chk("s4_no_ovf", 32'(overflow), 32'd0);
    keys_raw[8] = 1'b0;
    run(25);
    chk("s4_ovf", 32'(overflow), 32'd1);
    ev_ready = 1'b1;
    run(15);
    chk("s4_drained", 32'(ev_valid), 32'd0);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("s4_clr", 32'(overflow), 32'd0);
    keys_raw = '0;
    run(30);

    // Reset mid-cycle with events queued
    ev_ready = 1'b0;
    keys_raw[2:0] = 3'b111;
    run(20);
    chk("s6_queued", 32'(ev_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("s6_async_valid", 32'(ev_valid), 32'd0);
    chk("s6_async_stable", 32'(keys_stable), 32'd0);
    chk("s6_async_data", 32'(ev_data), 32'd0);
    model_reset();
    keys_raw = '0;
    run(2);
    rst = 1'b0;
    ev_ready = 1'b1;
    run(30);
    chk("s6_quiet", 32'(ev_valid), 32'd0);

    // Random key activity with varying consumer readiness
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 500; c++) begin
        if ($urandom_range(0, 14) == 0) keys_raw[$urandom_range(0, 12)] ^= 1'b1;
        ev_ready = ($urandom_range(0, 3) < ph);
        clr_ovf  = ($urandom_range(0, 59) == 0);
        step();
      end
    end
    clr_ovf = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/key_event_scanner.md
KEY_EVENT_SCANNER -- requirements
Module: key_event_scanner

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 50000, clock cycles per debounce sample tick (1 ms at 50 MHz).
REQ-002 SHALL have parameter DEB_TICKS, default 8, consecutive mismatching ticks needed to accept a key change (range 2..15).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, event FIFO entries (power of two).
REQ-004 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port keys_raw  input  13  unsynchronised, bouncing push-button levels, 1 = pressed.
REQ-007 SHALL have port keys_stable  output  13  debounced key levels; drives the system gpio_entrada bus.
REQ-008 SHALL have port ev_valid  output  1  event available at ev_data.
REQ-009 SHALL have port ev_ready  input  1  consumer accepts event when ev_valid && ev_ready.
REQ-010 SHALL have port ev_data  output  5  {press, key_index[3:0]}; press 1 = key went down, 0 = released.
REQ-011 SHALL have port overflow  output  1  sticky: a key edge was lost.
REQ-012 SHALL have port clr_ovf  input  1  synchronous clear of overflow.

Function
REQ-013 SHALL pass each keys_raw bit through a 2-flop synchroniser; sync value is the second flop.
REQ-014 SHALL run a tick counter 0..TICK_CYCLES-1, wrapping, asserting an internal tick for one cycle at TICK_CYCLES-1.
REQ-015 SHALL keep a per-key mismatch counter: on tick, sync != keys_stable increments it, sync == keys_stable clears it; no change between ticks.
REQ-016 SHALL, on the tick where a key's mismatch count reaches DEB_TICKS, flip that keys_stable bit, clear its counter, and set its pending bit, all in the same clock edge.
REQ-017 SHALL accept flips on several keys in the same tick independently.
REQ-018 SHALL, each cycle with any pending bit set and a FIFO push allowed, enqueue {keys_stable[i], i} for the lowest-index pending key i and clear pending[i]; one push per cycle maximum.
REQ-019 SHALL allow a push when FIFO not full, or when full and a pop occurs in the same cycle.
REQ-020 SHALL hold pending bits while pushes are blocked; no event dropped solely because the FIFO is full.
REQ-021 SHALL set overflow when a key flips while its pending bit is already set; pending stays set and the later state is reported.
REQ-022 SHALL clear overflow on clr_ovf unless a new overflow condition occurs in that cycle (set wins).
REQ-023 SHALL present the FIFO head on ev_data with ev_valid = FIFO not empty; ev_data SHALL stay stable while ev_valid && !ev_ready.
REQ-024 SHALL pop exactly one entry per cycle with ev_valid && ev_ready; ev_ready with FIFO empty has no effect.
REQ-025 SHALL give ev_valid the cycle after the push edge (FIFO registered, no bypass); key-flip-to-ev_valid latency = 2 cycles when FIFO empty and no other pending.
REQ-026 SHALL make FIFO pointers wrap modulo FIFO_DEPTH with separate full/empty detection (extra pointer bit or count).

Reset
REQ-027 SHALL, while rst high, force synchronisers, keys_stable, mismatch counters, tick counter, pending, FIFO pointers to 0, ev_valid 0, ev_data 0, overflow 0, independent of clk.
REQ-028 SHALL discard all queued and pending events on reset mid-operation; first tick after release occurs TICK_CYCLES cycles later.

Verification (TICK_CYCLES=4, DEB_TICKS=3, FIFO_DEPTH=8)
REQ-029 SHALL cover: keys_raw[0] 0->1 held -> keys_stable[0]=1 on the 3rd tick after sync value changes; ev_data=5'b1_0000 ev_valid two cycles later; release -> 5'b0_0000.
REQ-030 SHALL cover: keys_raw[2] toggling every 5 cycles for 60 cycles, then 0 -> keys_stable[2] stays 0, no event.
REQ-031 SHALL cover: keys_raw[0] and [12] rise same cycle, ev_ready=1 -> both stable bits rise same cycle; events 5'b1_0000 then 5'b1_1100 on consecutive cycles.
REQ-032 SHALL cover: ev_ready=0, 9 edges on keys 0..8 -> FIFO holds 8, pending[8] held, overflow 0; key 8 flips again -> overflow=1; ev_ready=1 drains 9 events in order, last reporting key 8 current state.
REQ-033 SHALL cover: FIFO full, ev_ready=1 and pending push same cycle -> both occur, count stays 8, head advances.
REQ-034 SHALL cover: 3 events queued, rst pulsed mid-cycle -> ev_valid=0 and keys_stable=0 immediately, no events after release until new debounced edges.
